// File: rtl/cycle_sequencer.sv
// Instruction step sequencer: one-hot step rotation with memory wait states,
// a wait-state timeout, halt/resume and single-cycle interrupt acknowledge.
module cycle_sequencer #(
    parameter int NSTEPS = 5,
    parameter int TO_W   = 4
) (
    input  logic              iClk,
    input  logic              nRst,
    input  logic              iRdy,
    input  logic [3:0]        iLen,
    input  logic              iMemStep,
    input  logic              iMemAck,
    input  logic              iHalt,
    input  logic              iRun,
    input  logic              iIrq,
    output logic [NSTEPS-1:0] oStep,
    output logic              oFetch,
    output logic              oMemReq,
    output logic              oInsnDone,
    output logic              oIrqAck,
    output logic              oHalted,
    output logic              oFault
);

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_IRQ   = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [NSTEPS-1:0] STEP0 = {{(NSTEPS-1){1'b0}}, 1'b1};

    logic [2:0]        state, state_nx;
    logic [NSTEPS-1:0] step, step_nx;
    logic [TO_W-1:0]   cnt, cnt_nx;

    logic [4:0]        len_ext;
    logic [4:0]        eff_len;
    logic [NSTEPS-1:0] last_mask;
    logic [NSTEPS-1:0] step_rot;
    logic              is_last;
    logic              adv;
    logic              stall;
    logic              timeout;

    // Effective length is clamped to [2, NSTEPS]; step 0 can never be last.
    always_comb begin
        len_ext = {1'b0, iLen};
        if (len_ext < 5'd2)
            eff_len = 5'd2;
        else if (len_ext > 5'(NSTEPS))
            eff_len = 5'(NSTEPS);
        else
            eff_len = len_ext;
    end

    assign last_mask = STEP0 << (eff_len - 5'd1);
    assign is_last   = |(step & last_mask);
    assign step_rot  = {step[NSTEPS-2:0], step[NSTEPS-1]};

    assign adv     = iRdy && (((state == S_RUN) && (!iMemStep || iMemAck)) ||
                              ((state == S_WAIT) && iMemAck));
    assign stall   = iRdy && (state == S_RUN) && iMemStep && !iMemAck;
    assign timeout = iRdy && (state == S_WAIT) && !iMemAck && (cnt == '1);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        cnt_nx   = cnt;
        if (adv) begin
            if (is_last) begin
                step_nx = STEP0;
                if (iHalt)
                    state_nx = S_HALT;
                else if (iIrq)
                    state_nx = S_IRQ;
                else
                    state_nx = S_RUN;
            end else begin
                step_nx  = step_rot;
                state_nx = S_RUN;
            end
        end else if (stall) begin
            state_nx = S_WAIT;
            cnt_nx   = '0;
        end else if (timeout) begin
            state_nx = S_FAULT;
            step_nx  = STEP0;
        end else if (iRdy) begin
            case (state)
                S_WAIT: cnt_nx = cnt + 1'b1;
                S_IRQ:  state_nx = S_RUN;
                S_HALT: begin
                    if (iIrq)
                        state_nx = S_IRQ;
                    else if (iRun)
                        state_nx = S_RUN;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state <= S_RUN;
            step  <= STEP0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
            cnt   <= cnt_nx;
        end
    end

    // Step is only visible while an instruction is in flight.
    assign oStep     = ((state == S_RUN) || (state == S_WAIT)) ? step : '0;
    assign oFetch    = (state == S_RUN) && step[0];
    assign oMemReq   = ((state == S_RUN) && iMemStep) || (state == S_WAIT);
    assign oInsnDone = adv && is_last;
    assign oIrqAck   = (state == S_IRQ) && iRdy;
    assign oHalted   = (state == S_HALT);
    assign oFault    = (state == S_FAULT);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Scoreboard bench for cycle_sequencer (NSTEPS=5, TO_W=3): expected outputs
// are queued with each cycle's stimulus and compared mid-cycle by a monitor.
module tb_cycle_sequencer;

    logic       iClk = 1'b0;
    logic       nRst = 1'b0;
    logic       iRdy = 1'b0;
    logic [3:0] iLen = 4'd0;
    logic       iMemStep = 1'b0;
    logic       iMemAck = 1'b0;
    logic       iHalt = 1'b0;
    logic       iRun = 1'b0;
    logic       iIrq = 1'b0;
    logic [4:0] oStep;
    logic       oFetch, oMemReq, oInsnDone, oIrqAck, oHalted, oFault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [4:0] step;
        logic       mem;
        logic       done;
        logic       ack;
        logic       halted;
        logic       fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    cycle_sequencer #(.NSTEPS(5), .TO_W(3)) dut (
        .iClk(iClk), .nRst(nRst), .iRdy(iRdy), .iLen(iLen),
        .iMemStep(iMemStep), .iMemAck(iMemAck), .iHalt(iHalt),
        .iRun(iRun), .iIrq(iIrq), .oStep(oStep), .oFetch(oFetch),
        .oMemReq(oMemReq), .oInsnDone(oInsnDone), .oIrqAck(oIrqAck),
        .oHalted(oHalted), .oFault(oFault)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be during it.
    task automatic tick(input string tag, input logic [3:0] len, input logic mem, input logic ack,
                        input logic halt, input logic irq, input logic run, input logic rdy,
                        input logic [4:0] e_step, input logic e_mem, input logic e_done,
                        input logic e_ack, input logic e_halted, input logic e_fault);
        exp_t e;
        @(negedge iClk);
        iLen = len; iMemStep = mem; iMemAck = ack;
        iHalt = halt; iIrq = irq; iRun = run; iRdy = rdy;
        e.tag = tag; e.step = e_step; e.mem = e_mem; e.done = e_done;
        e.ack = e_ack; e.halted = e_halted; e.fault = e_fault;
        sb.push_back(e);
    endtask

    task automatic rst_pulse(input string tag);
        @(negedge iClk);
        iRdy = 1'b0; iMemStep = 1'b0; iMemAck = 1'b0;
        iHalt = 1'b0; iIrq = 1'b0; iRun = 1'b0;
        #2 nRst = 1'b0;
        #1;
        check({tag, "_step"}, 32'(oStep), 32'd1);
        check({tag, "_fetch"}, 32'(oFetch), 32'd1);
        check({tag, "_memreq"}, 32'(oMemReq), 32'd0);
        check({tag, "_fault"}, 32'(oFault), 32'd0);
        check({tag, "_halted"}, 32'(oHalted), 32'd0);
        @(negedge iClk);
        nRst = 1'b1;
    endtask

    always begin
        @(negedge iClk);
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, "_step"},   32'(oStep),     32'(mon_e.step));
            check({mon_e.tag, "_fetch"},  32'(oFetch),    32'(mon_e.step[0]));
            check({mon_e.tag, "_memreq"}, 32'(oMemReq),   32'(mon_e.mem));
            check({mon_e.tag, "_done"},   32'(oInsnDone), 32'(mon_e.done));
            check({mon_e.tag, "_irqack"}, 32'(oIrqAck),   32'(mon_e.ack));
            check({mon_e.tag, "_halted"}, 32'(oHalted),   32'(mon_e.halted));
            check({mon_e.tag, "_fault"},  32'(oFault),    32'(mon_e.fault));
        end
    end

    initial begin
        #12;
        check("reset_step", 32'(oStep), 32'd1);
        check("reset_fetch", 32'(oFetch), 32'd1);
        check("reset_flags", {26'd0, oMemReq, oInsnDone, oIrqAck, oHalted, oFault, 1'b0}, 32'd0);
        @(negedge iClk);
        nRst = 1'b1;

        // Full-length instruction, memory access at fetch acked immediately
        tick("seq5", 5, 1, 1, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0);
        tick("seq5", 5, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("seq5", 5, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("seq5", 5, 0, 0, 0, 0, 0, 1,  8, 0, 0, 0, 0, 0);
        tick("seq5", 5, 0, 0, 0, 0, 0, 1, 16, 0, 1, 0, 0, 0);
        // Length clamping: 3, then 0 -> 2, then 9 -> 5
        tick("len3", 3, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("len3", 3, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("len3", 3, 0, 0, 0, 0, 0, 1,  4, 0, 1, 0, 0, 0);
        tick("len0", 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("len0", 0, 0, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 0);
        tick("len9", 9, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("len9", 9, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("len9", 9, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("len9", 9, 0, 0, 0, 0, 0, 1,  8, 0, 0, 0, 0, 0);
        tick("len9", 9, 0, 0, 0, 0, 0, 1, 16, 0, 1, 0, 0, 0);
        // Wait states: ack arrives in the fourth WAIT cycle
        tick("wait", 5, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("wait", 5, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("wait", 5, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("wait", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            tick("wait_hold", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        tick("wait_ack", 5, 1, 1, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        tick("wait_post", 5, 0, 0, 0, 0, 0, 1, 16, 0, 1, 0, 0, 0);
        // Ack never arrives: FAULT after 8 WAIT cycles
        tick("tmo", 5, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("tmo", 5, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("tmo", 5, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("tmo", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            tick("tmo_wait", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        tick("tmo_fault", 5, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        tick("fault_sticky", 5, 1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 1);
        rst_pulse("rst_fault");
        // Halt with irq pending: halt wins, then irq beats run in HALT
        tick("halt", 2, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("halt", 2, 0, 0, 1, 1, 0, 1,  2, 0, 1, 0, 0, 0);
        tick("halt_hold", 2, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        tick("halt_irq", 2, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 1, 0);
        tick("irq_ack", 2, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        tick("irq_post", 2, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        // Halt resumed by iRun: no acknowledge
        tick("run", 2, 0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 0);
        tick("run_halt", 2, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        tick("run_post", 2, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        // Interrupt taken directly at the end of an instruction
        tick("irq", 2, 0, 0, 0, 1, 0, 1,  2, 0, 1, 0, 0, 0);
        tick("irq_only", 2, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        tick("irq_only_post", 2, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        // iRdy low mid-instruction and on the last step
        tick("rdy", 5, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            tick("rdy_low_mid", 5, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0);
        tick("rdy", 5, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("rdy", 5, 0, 0, 0, 0, 0, 1,  8, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            tick("rdy_low_last", 5, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0, 0, 0);
        tick("rdy_last", 5, 0, 0, 0, 0, 0, 1, 16, 0, 1, 0, 0, 0);
        // iRdy low mid-WAIT freezes the timeout counter
        tick("rdyw", 5, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("rdyw", 5, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("rdyw", 5, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("rdyw", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            tick("rdyw_wait", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            tick("rdyw_frozen", 5, 1, 1, 0, 0, 0, 0,  8, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            tick("rdyw_resume", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        tick("rdyw_fault", 5, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
        rst_pulse("rst_fault2");
        // Reset while in WAIT
        tick("rw", 5, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("rw", 5, 0, 0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 0);
        tick("rw", 5, 0, 0, 0, 0, 0, 1,  4, 0, 0, 0, 0, 0);
        tick("rw", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        tick("rw_wait", 5, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 0);
        rst_pulse("rst_wait");
        // Reset while in HALT
        tick("rh", 2, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("rh", 2, 0, 0, 1, 0, 0, 1,  2, 0, 1, 0, 0, 0);
        tick("rh_halt", 2, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0);
        rst_pulse("rst_halt");
        tick("rh_post", 2, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
        tick("rh_post", 2, 0, 0, 0, 0, 0, 1,  2, 0, 1, 0, 0, 0);

        @(negedge iClk);
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
